// File: rtl/mjpg_stream_parser_pkg.sv
// Shared definitions for the MJPG receive parser: marker codes, FSM states
// and the SOF0 payload offsets of the geometry fields.
package mjpg_pkg;

    localparam logic [7:0] M_SOI  = 8'hD8;
    localparam logic [7:0] M_EOI  = 8'hD9;
    localparam logic [7:0] M_SOF0 = 8'hC0;
    localparam logic [7:0] M_DHT  = 8'hC4;
    localparam logic [7:0] M_SOS  = 8'hDA;
    localparam logic [7:0] M_DQT  = 8'hDB;
    localparam logic [7:0] M_DRI  = 8'hDD;
    localparam logic [7:0] M_RST0 = 8'hD0;
    localparam logic [7:0] M_COM  = 8'hFE;

    // Payload byte index of the MSB of Y (height) and X (width) in SOF0
    localparam logic [2:0] SOF_Y_OFS = 3'd1;
    localparam logic [2:0] SOF_X_OFS = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MARK,
        S_LEN_HI,
        S_LEN_LO,
        S_SEG,
        S_SCAN,
        S_SCAN_FF
    } state_t;

    // Markers that are followed by a 16-bit length and a payload
    function automatic logic has_length(input logic [7:0] code);
        return (code == M_SOF0) || (code == M_DHT) || (code == M_SOS) ||
               (code == M_DQT) || (code == M_DRI) || (code[7:4] == 4'hE) ||
               (code == M_COM);
    endfunction

    function automatic logic is_rst(input logic [7:0] code);
        return code[7:3] == M_RST0[7:3];
    endfunction

endpackage

// File: rtl/mjpg_stream_parser.sv
// MJPG receive front end: follows marker/segment structure, captures SOF0
// geometry and removes FF 00 stuffing from scan data.
//
// state     | meaning
// S_IDLE    | hunting for FF
// S_MARK    | FF seen outside scan, next byte is a marker code
// S_LEN_HI  | segment length MSB
// S_LEN_LO  | segment length LSB
// S_SEG     | skipping / capturing segment payload
// S_SCAN    | entropy-coded data
// S_SCAN_FF | FF seen inside scan
module mjpg_stream_parser
    import mjpg_pkg::*;
#(
    parameter int MAX_SEG = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jvalid,
    input  logic [7:0]  jpeg,
    output logic        svalid,
    output logic [7:0]  sdata,
    output logic        sof,
    output logic        eof,
    output logic        rstm,
    output logic        hdr_valid,
    output logic [15:0] width,
    output logic [15:0] height,
    output logic        err
);

    localparam logic [16:0] MAX_SEG_W = 17'(MAX_SEG);
    localparam logic [2:0]  Y_LSB     = SOF_Y_OFS + 3'd1;
    localparam logic [2:0]  X_LSB     = SOF_X_OFS + 3'd1;

    state_t      state, state_nxt;
    logic [7:0]  marker;
    logic [7:0]  len_hi;
    logic [15:0] remaining;
    logic [2:0]  idx;

    logic [15:0] len_cur;
    logic        len_bad;
    logic        is_ff;
    logic        sos_seg;

    logic        emit_d, sof_d, eof_d, rstm_d, err_d;
    logic [7:0]  emit_byte;

    assign len_cur = {len_hi, jpeg};
    assign len_bad = (len_cur < 16'd2) || ({1'b0, len_cur} > MAX_SEG_W);
    assign is_ff   = (jpeg == 8'hFF);
    assign sos_seg = (marker == M_SOS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (jvalid) begin
            case (state)
                S_IDLE:   if (is_ff) state_nxt = S_MARK;
                S_MARK: begin
                    if (is_ff)                 state_nxt = S_MARK;
                    else if (has_length(jpeg)) state_nxt = S_LEN_HI;
                    else                       state_nxt = S_IDLE;
                end
                S_LEN_HI: state_nxt = S_LEN_LO;
                S_LEN_LO: begin
                    if (len_bad)                state_nxt = S_IDLE;
                    else if (len_cur == 16'd2) state_nxt = sos_seg ? S_SCAN : S_IDLE;
                    else                        state_nxt = S_SEG;
                end
                S_SEG:    if (remaining == 16'd1) state_nxt = sos_seg ? S_SCAN : S_IDLE;
                S_SCAN:   if (is_ff) state_nxt = S_SCAN_FF;
                S_SCAN_FF: begin
                    if (jpeg == 8'h00 || is_rst(jpeg)) state_nxt = S_SCAN;
                    else if (is_ff)                    state_nxt = S_SCAN_FF;
                    else                               state_nxt = S_IDLE;
                end
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        emit_d    = 1'b0;
        emit_byte = jpeg;
        sof_d     = 1'b0;
        eof_d     = 1'b0;
        rstm_d    = 1'b0;
        err_d     = 1'b0;
        if (jvalid) begin
            case (state)
                S_MARK: begin
                    if (jpeg == M_SOI)      sof_d = 1'b1;
                    else if (jpeg == M_EOI) eof_d = 1'b1;
                    else if (!is_ff && !has_length(jpeg)) err_d = 1'b1;
                end
                S_LEN_LO: err_d = len_bad;
                S_SCAN:   emit_d = !is_ff;
                S_SCAN_FF: begin
                    if (jpeg == 8'h00) begin
                        emit_d    = 1'b1;
                        emit_byte = 8'hFF;
                    end else if (is_rst(jpeg)) begin
                        rstm_d = 1'b1;
                    end else if (jpeg == M_EOI) begin
                        eof_d = 1'b1;
                    end else if (jpeg == M_SOI) begin
                        // encoder restarted mid-frame: flag it, but still open the new frame
                        err_d = 1'b1;
                        sof_d = 1'b1;
                    end else if (!is_ff) begin
                        err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            svalid    <= 1'b0;
            sdata     <= 8'h00;
            sof       <= 1'b0;
            eof       <= 1'b0;
            rstm      <= 1'b0;
            err       <= 1'b0;
            hdr_valid <= 1'b0;
            width     <= 16'h0000;
            height    <= 16'h0000;
            marker    <= 8'h00;
            len_hi    <= 8'h00;
            remaining <= 16'h0000;
            idx       <= 3'd0;
        end else begin
            svalid <= emit_d;
            sof    <= sof_d;
            eof    <= eof_d;
            rstm   <= rstm_d;
            err    <= err_d;
            if (emit_d) sdata <= emit_byte;
            if (sof_d)  hdr_valid <= 1'b0;
            if (jvalid) begin
                case (state)
                    S_MARK:   if (has_length(jpeg)) marker <= jpeg;
                    S_LEN_HI: len_hi <= jpeg;
                    S_LEN_LO: begin
                        remaining <= len_cur - 16'd2;
                        idx       <= 3'd0;
                    end
                    S_SEG: begin
                        remaining <= remaining - 16'd1;
                        if (idx != 3'd7) idx <= idx + 3'd1;
                        if (marker == M_SOF0) begin
                            case (idx)
                                SOF_Y_OFS: height[15:8] <= jpeg;
                                Y_LSB:     height[7:0]  <= jpeg;
                                SOF_X_OFS: width[15:8]  <= jpeg;
                                X_LSB: begin
                                    width[7:0] <= jpeg;
                                    hdr_valid  <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mjpg_stream_parser.sv
// Scoreboard bench for mjpg_stream_parser: directed byte streams push expected
// events; a negedge monitor pops and compares every output event and its latency.
module tb_mjpg_stream_parser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        jvalid = 1'b0;
    logic [7:0]  jpeg = 8'h00;
    logic        svalid, sof, eof, rstm, hdr_valid, err;
    logic [7:0]  sdata;
    logic [15:0] width, height;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mjpg_stream_parser #(.MAX_SEG(64)) dut (
        .clk(clk), .rst_n(rst_n), .jvalid(jvalid), .jpeg(jpeg),
        .svalid(svalid), .sdata(sdata), .sof(sof), .eof(eof), .rstm(rstm),
        .hdr_valid(hdr_valid), .width(width), .height(height), .err(err)
    );

    typedef enum int {K_NONE, K_SV, K_SOF, K_EOF, K_RST, K_ERR, K_HDR, K_HCLR} kind_t;
    typedef struct {
        kind_t       k;
        logic [31:0] d;
        int          c;
    } ev_t;

    ev_t  q[$];
    int   checks = 0;
    int   errors = 0;
    int   gap_max = 0;
    logic prev_hdr = 1'b0;

    localparam logic [31:0] GEOM = {16'h0280, 16'h0168};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input kind_t k, input logic [31:0] d);
        q.push_back('{k, d, cyc});
    endtask

    task automatic tx(input logic [7:0] b, input kind_t k = K_NONE, input logic [31:0] d = 0);
        int gap;
        gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        repeat (gap) begin
            @(negedge clk);
            jvalid = 1'b0;
        end
        @(negedge clk);
        jvalid = 1'b1;
        jpeg   = b;
        if (k != K_NONE) expect_ev(k, d);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            jvalid = 1'b0;
        end
    endtask

    task automatic obs(input kind_t k, input logic [31:0] d);
        ev_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event actual=%s/%h at cycle %0d required=none", k.name(), d, cyc);
        end else begin
            e = q.pop_front();
            if (e.k != k || e.d !== d || e.c + 1 != cyc)
            begin
                errors++;
                $display("FAIL event actual=%s/%h@%0d required=%s/%h@%0d",
                         k.name(), d, cyc, e.k.name(), e.d, e.c + 1);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hdr = 1'b0;
        end else begin
            if (err)                   obs(K_ERR, 0);
            if (sof)                   obs(K_SOF, 0);
            if (!hdr_valid && prev_hdr) obs(K_HCLR, 0);
            if (eof)                   obs(K_EOF, 0);
            if (rstm)                  obs(K_RST, 0);
            if (svalid)                obs(K_SV, {24'h0, sdata});
            if (hdr_valid && !prev_hdr) obs(K_HDR, {width, height});
            prev_hdr = hdr_valid;
        end
    end

    task automatic sof0_seg();
        tx(8'hFF); tx(8'hC0); tx(8'h00); tx(8'h11);
        tx(8'h08); tx(8'h01); tx(8'h68); tx(8'h02); tx(8'h80, K_HDR, GEOM);
        tx(8'h03);
        tx(8'h01); tx(8'h22); tx(8'h00);
        tx(8'h02); tx(8'h11); tx(8'h01);
        tx(8'h03); tx(8'h11); tx(8'h01);
    endtask

    task automatic full_frame(input bit hdr_was);
        tx(8'hFF);
        tx(8'hD8, K_SOF);
        if (hdr_was) expect_ev(K_HCLR, 0);
        sof0_seg();
        tx(8'hFF); tx(8'hDA); tx(8'h00); tx(8'h0C);
        tx(8'h03); tx(8'h01); tx(8'h00); tx(8'h02); tx(8'h11);
        tx(8'h03); tx(8'h11); tx(8'h00); tx(8'h3F); tx(8'h00);
        tx(8'h12, K_SV, 32'h12);
        tx(8'h34, K_SV, 32'h34);
        tx(8'hFF);
        tx(8'hD9, K_EOF);
    endtask

    task automatic chk_reset_values();
        chk("rst_svalid", {31'h0, svalid}, 0);
        chk("rst_sdata", {24'h0, sdata}, 0);
        chk("rst_sof", {31'h0, sof}, 0);
        chk("rst_eof", {31'h0, eof}, 0);
        chk("rst_rstm", {31'h0, rstm}, 0);
        chk("rst_err", {31'h0, err}, 0);
        chk("rst_hdr_valid", {31'h0, hdr_valid}, 0);
        chk("rst_width", {16'h0, width}, 0);
        chk("rst_height", {16'h0, height}, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_reset_values();
        rst_n = 1'b1;
        idle(2);

        // clean frame
        full_frame(1'b0);
        idle(2);

        // L=2 SOS goes straight to scan; stuffing, restart marker and fill
        tx(8'hFF); tx(8'hDA); tx(8'h00); tx(8'h02);
        tx(8'hAB, K_SV, 32'hAB);
        tx(8'hFF);
        tx(8'h00, K_SV, 32'hFF);
        tx(8'hCD, K_SV, 32'hCD);
        tx(8'h11, K_SV, 32'h11);
        tx(8'hFF);
        tx(8'hD3, K_RST);
        tx(8'h22, K_SV, 32'h22);
        tx(8'hFF); tx(8'hFF);
        tx(8'hD9, K_EOF);

        // L=2 on a non-SOS marker returns to idle
        tx(8'hFF); tx(8'hFE); tx(8'h00); tx(8'h02);
        tx(8'hFF); tx(8'hD9, K_EOF);

        // garbage in idle is silent; unknown marker code is an error
        tx(8'h55); tx(8'hAA);
        tx(8'hFF); tx(8'h01, K_ERR);

        // length below 2, then recovery on SOI
        tx(8'hFF); tx(8'hDB); tx(8'h00); tx(8'h01, K_ERR);
        tx(8'hFF); tx(8'hD8, K_SOF);
        expect_ev(K_HCLR, 0);

        // length just above and exactly at MAX_SEG (64)
        tx(8'hFF); tx(8'hE0); tx(8'h00); tx(8'h41, K_ERR);
        tx(8'hFF); tx(8'hE0); tx(8'h00); tx(8'h40);
        for (int i = 0; i < 62; i++) tx(8'hFF);
        tx(8'hFF); tx(8'hD9, K_EOF);

        // SOI inside scan
        sof0_seg();
        tx(8'hFF); tx(8'hDA); tx(8'h00); tx(8'h02);
        tx(8'h77, K_SV, 32'h77);
        tx(8'hFF);
        tx(8'hD8, K_ERR);
        expect_ev(K_SOF, 0);
        expect_ev(K_HCLR, 0);
        idle(2);

        // same frame with random idle gaps
        gap_max = 3;
        full_frame(1'b0);
        gap_max = 0;
        idle(2);

        // async reset in the middle of a DQT payload
        tx(8'hFF);
        tx(8'hD8, K_SOF);
        expect_ev(K_HCLR, 0);
        sof0_seg();
        tx(8'hFF); tx(8'hDB); tx(8'h00); tx(8'h05); tx(8'h01); tx(8'h02);
        idle(3);
        chk("pre_reset_hdr_valid", {31'h0, hdr_valid}, 1);
        #2 rst_n = 1'b0;
        #2 chk_reset_values();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        full_frame(1'b0);
        idle(5);

        chk("scoreboard_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
